// File: rtl/mux_serializer_pkg.sv
// Shared definitions for the word-to-bit serializer: sequencer state encoding
// and the width of the bit-select bus.
package mux_serializer_pkg;

  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/mux_serializer_mux.sv
// 16:1 single-bit multiplexer; purely combinational, driven by the serializer's
// held word and bit-select counter.
module mux_16to1
  import mux_serializer_pkg::*;
(
  input  logic [15:0]      data,
  input  logic [SEL_W-1:0] sel,
  output logic             out
);

  assign out = data[sel];

endmodule

// File: rtl/mux_serializer.sv
// Parallel-in/serial-out stage: captures a word, steps the mux select through
// every bit and presents each bit on a valid/ready output with a last flag.
module mux_serializer
  import mux_serializer_pkg::*;
#(
  parameter int WIDTH     = 16,  // 8 or 16
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic [SEL_W-1:0] sel
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and in_ready never depends on in_valid.

  localparam logic [SEL_W-1:0] START = LSB_FIRST ? SEL_W'(0) : SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] END   = LSB_FIRST ? SEL_W'(WIDTH - 1) : SEL_W'(0);

  state_t           state;
  logic [WIDTH-1:0] word_q;
  logic [SEL_W-1:0] sel_q;
  logic [15:0]      mux_data;

  assign sel       = sel_q;
  assign out_valid = (state == SHIFT);
  assign out_last  = (state == SHIFT) && (sel_q == END);
  assign in_ready  = (state == IDLE) || ((state == SHIFT) && out_last && out_ready);

  always_comb begin
    mux_data              = '0;
    mux_data[WIDTH-1:0]   = word_q;
  end

  mux_16to1 u_mux (
    .data (mux_data),
    .sel  (sel_q),
    .out  (out_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      word_q <= '0;
      sel_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word_q <= in_data;
            sel_q  <= START;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (!out_last) begin
              sel_q <= LSB_FIRST ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);
            end else if (in_valid) begin
              // Back-to-back word: reload without passing through IDLE.
              word_q <= in_data;
              sel_q  <= START;
            end else begin
              sel_q <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// Directed bench for mux_serializer: one LSB-first and one MSB-first instance
// share stimulus; outputs are checked at the falling edge.
module tb_mux_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic       l_in_ready, l_out_valid, l_out_bit, l_out_last;
  logic [3:0] l_sel;
  logic       m_in_ready, m_out_valid, m_out_bit, m_out_last;
  logic [3:0] m_sel;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] l_sel;
    logic       l_bit;
    logic       l_last;
    logic [3:0] m_sel;
    logic       m_bit;
    logic       m_last;
  } vec_t;

  vec_t tbl[16];

  mux_serializer #(.WIDTH(16), .LSB_FIRST(1'b1)) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (l_in_ready),
    .in_data   (in_data),
    .out_valid (l_out_valid),
    .out_ready (out_ready),
    .out_bit   (l_out_bit),
    .out_last  (l_out_last),
    .sel       (l_sel)
  );

  mux_serializer #(.WIDTH(16), .LSB_FIRST(1'b0)) dut_msb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (m_in_ready),
    .in_data   (in_data),
    .out_valid (m_out_valid),
    .out_ready (out_ready),
    .out_bit   (m_out_bit),
    .out_last  (m_out_last),
    .sel       (m_sel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver: present a word before the next rising edge, drop valid after it
  task automatic send_word(input logic [15:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    // 16'hA5C3 expected stream for both bit orders
    tbl[0]  = '{4'd0,  1'b1, 1'b0, 4'd15, 1'b1, 1'b0};
    tbl[1]  = '{4'd1,  1'b1, 1'b0, 4'd14, 1'b0, 1'b0};
    tbl[2]  = '{4'd2,  1'b0, 1'b0, 4'd13, 1'b1, 1'b0};
    tbl[3]  = '{4'd3,  1'b0, 1'b0, 4'd12, 1'b0, 1'b0};
    tbl[4]  = '{4'd4,  1'b0, 1'b0, 4'd11, 1'b0, 1'b0};
    tbl[5]  = '{4'd5,  1'b0, 1'b0, 4'd10, 1'b1, 1'b0};
    tbl[6]  = '{4'd6,  1'b1, 1'b0, 4'd9,  1'b0, 1'b0};
    tbl[7]  = '{4'd7,  1'b1, 1'b0, 4'd8,  1'b1, 1'b0};
    tbl[8]  = '{4'd8,  1'b1, 1'b0, 4'd7,  1'b1, 1'b0};
    tbl[9]  = '{4'd9,  1'b0, 1'b0, 4'd6,  1'b1, 1'b0};
    tbl[10] = '{4'd10, 1'b1, 1'b0, 4'd5,  1'b0, 1'b0};
    tbl[11] = '{4'd11, 1'b0, 1'b0, 4'd4,  1'b0, 1'b0};
    tbl[12] = '{4'd12, 1'b0, 1'b0, 4'd3,  1'b0, 1'b0};
    tbl[13] = '{4'd13, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0};
    tbl[14] = '{4'd14, 1'b0, 1'b0, 4'd1,  1'b1, 1'b0};
    tbl[15] = '{4'd15, 1'b1, 1'b1, 4'd0,  1'b1, 1'b1};

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b1;

    // 1: asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 16'(l_out_valid), 16'h0);
    check("rst_sel",       16'(l_sel),       16'h0);
    check("rst_out_last",  16'(l_out_last),  16'h0);
    check("rst_out_bit",   16'(l_out_bit),   16'h0);
    check("rst_msb_valid", 16'(m_out_valid), 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready_lsb", 16'(l_in_ready), 16'h1);
    check("rst_in_ready_msb", 16'(m_in_ready), 16'h1);

    // 2 & 3: table-driven A5C3 stream, both orders, no backpressure
    send_word(16'hA5C3);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("a5_lsb_valid[%0d]", i), 16'(l_out_valid), 16'h1);
      check($sformatf("a5_lsb_sel[%0d]", i),   16'(l_sel),       16'(tbl[i].l_sel));
      check($sformatf("a5_lsb_bit[%0d]", i),   16'(l_out_bit),   16'(tbl[i].l_bit));
      check($sformatf("a5_lsb_last[%0d]", i),  16'(l_out_last),  16'(tbl[i].l_last));
      check($sformatf("a5_lsb_ready[%0d]", i), 16'(l_in_ready),  16'(tbl[i].l_last));
      check($sformatf("a5_msb_sel[%0d]", i),   16'(m_sel),       16'(tbl[i].m_sel));
      check($sformatf("a5_msb_bit[%0d]", i),   16'(m_out_bit),   16'(tbl[i].m_bit));
      check($sformatf("a5_msb_last[%0d]", i),  16'(m_out_last),  16'(tbl[i].m_last));
    end
    @(negedge clk);
    check("a5_lsb_idle_valid", 16'(l_out_valid), 16'h0);
    check("a5_lsb_idle_ready", 16'(l_in_ready),  16'h1);
    check("a5_msb_idle_valid", 16'(m_out_valid), 16'h0);
    check("a5_msb_idle_ready", 16'(m_in_ready),  16'h1);

    // 4: backpressure on 16'h8001, three stall cycles at sel=4
    begin
      int idx    = 0;
      int stalls = 0;
      int shakes = 0;
      send_word(16'h8001);
      for (int cyc = 0; cyc < 40 && idx < 16; cyc++) begin
        @(negedge clk);
        check($sformatf("bp_valid[%0d]", cyc), 16'(l_out_valid), 16'h1);
        check($sformatf("bp_sel[%0d]", cyc),   16'(l_sel),       16'(idx));
        check($sformatf("bp_bit[%0d]", cyc),   16'(l_out_bit),   16'((idx == 0) || (idx == 15)));
        if (idx == 4 && stalls < 3) begin
          out_ready = 1'b0;
          stalls++;
        end else begin
          out_ready = 1'b1;
        end
        if (out_ready && l_out_valid) begin
          idx++;
          shakes++;
        end
      end
      check("bp_handshakes", 16'(shakes), 16'd16);
      check("bp_stalls",     16'(stalls), 16'd3);
      @(negedge clk);
      check("bp_idle_valid", 16'(l_out_valid), 16'h0);
    end

    // 5: back-to-back FFFF then 0000 with in_valid held
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hFFFF;
    @(posedge clk);
    #1;
    in_data = 16'h0000;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      check($sformatf("b2b_valid[%0d]", k), 16'(l_out_valid), 16'h1);
      check($sformatf("b2b_bit[%0d]", k),   16'(l_out_bit),   16'(k < 16));
      check($sformatf("b2b_sel[%0d]", k),   16'(l_sel),       16'(k % 16));
      check($sformatf("b2b_ready[%0d]", k), 16'(l_in_ready),  16'((k == 15) || (k == 31)));
      if (k == 31) in_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle_valid", 16'(l_out_valid), 16'h0);

    // 6: reset mid-word at sel=7, reset wins over in_valid, then a clean word
    send_word(16'h1234);
    repeat (8) @(negedge clk);
    check("mid_sel_before_rst", 16'(l_sel), 16'd7);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 16'(l_out_valid), 16'h0);
    check("mid_rst_sel",   16'(l_sel),       16'h0);
    check("mid_rst_last",  16'(l_out_last),  16'h0);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    @(negedge clk);
    check("rst_wins_valid", 16'(l_out_valid), 16'h0);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 16'(l_out_valid), 16'h0);
    check("post_rst_ready", 16'(l_in_ready),  16'h1);
    send_word(16'h0001);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("rs_sel[%0d]", k),  16'(l_sel),      16'(k));
      check($sformatf("rs_bit[%0d]", k),  16'(l_out_bit),  16'(k == 0));
      check($sformatf("rs_last[%0d]", k), 16'(l_out_last), 16'(k == 15));
    end
    @(negedge clk);
    check("rs_idle_valid", 16'(l_out_valid), 16'h0);

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
